// File: rtl/fp16_to_int16.sv
// -----------------------------------------------------------------------------
// fp16_to_int16
//   Sequential accelerator that converts an IEEE-754 binary16 operand held in
//   its own byte-wide data memory into a 16-bit integer. Rounding is to the
//   nearest integer, with ties going away from zero. The result is written
//   back to the same memory.
//
//   Memory map (big-endian):
//     mem[4], mem[5] : operand bits 15:8, 7:0
//     mem[6], mem[7] : result  bits 15:8, 7:0
//
//   Ports:
//     clk   in  : single clock; all state changes on posedge
//     reset in  : synchronous, active-high reset
//     req   in  : start request; sampled at a posedge while IDLE or DONE
//     ack   out : done flag; the result in memory is valid while ack=1
//
//   Latency: from the acceptance edge to ack rising takes at most 16 cycles.
//   The guaranteed bound is 48 cycles.
//
//   Build option:
//     FLT2INT_SAT_EN : when defined, out-of-range results saturate to
//                      0x7FFF / 0x8000. Inf/NaN saturate by sign.
//                      When undefined, results wrap to 16 bits and Inf/NaN
//                      store 0x8000.
//
//   The data memory is instance dm1. Its array mem_core is reachable
//   hierarchically, so operands and results can be accessed by backdoor.
// -----------------------------------------------------------------------------

// Byte-wide data memory.
//   clk       in  : write clock
//   we_i      in  : write enable
//   waddr_i   in  : write address
//   wdata_i   in  : write data
//   raddr_a_i in  : address for read port A
//   raddr_b_i in  : address for read port B
//   rdata_a_o out : combinational read data, port A
//   rdata_b_o out : combinational read data, port B
module fp16_to_int16_dm #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [7:0]    rdata_a_o,
   output logic [7:0]    rdata_b_o
);

   logic [7:0] mem_core [DEPTH];

   // NOTE: the storage array has no reset. A reset loop over every entry
   // would prevent RAM inference, and the contents are owned by software.
   always_ff @(posedge clk) begin
      if (we_i) mem_core[waddr_i] <= wdata_i;
   end

   assign rdata_a_o = mem_core[raddr_a_i];
   assign rdata_b_o = mem_core[raddr_b_i];

endmodule

module fp16_to_int16 (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic ack
);

   localparam int DM_DEPTH = 256;
   localparam int AW       = $clog2(DM_DEPTH);
   localparam int ADDR_IN  = 4;
   localparam int ADDR_OUT = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DECODE,
      S_SHIFT,
      S_ROUND,
      S_STORE_HI,
      S_STORE_LO,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [15:0] op_q;     // captured operand
   logic [16:0] acc_q;    // |value| * 2: bit 0 is the guard (0.5) bit
   logic [4:0]  cnt_q;    // remaining shift steps
   logic        left_q;   // shift direction: 1 = left, 0 = right
   logic [15:0] res_q;    // final 16-bit result
   logic        ack_q;

   // Memory interface
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;
   logic [7:0]    rd_hi;
   logic [7:0]    rd_lo;

   // Operand fields
   logic        sign;
   logic [4:0]  exp_f;
   logic [10:0] mant;

   assign sign  = op_q[15];
   assign exp_f = op_q[14:10];
   assign mant  = {|exp_f, op_q[9:0]};

   // Decode: the accumulator starts as m, which is |v| * 2^(25-e).
   // To reach the |v| * 2 fixed-point form it is shifted right by 24-e,
   // or left by e-24. The range e=14..30 therefore needs at most
   // 10 right shifts or 6 left shifts. With e<=13, |v| < 0.5, so the
   // result is 0. This also covers zero and subnormals.
   logic [16:0] dec_acc;
   logic [4:0]  dec_cnt;
   logic        dec_left;

   always_comb begin
      // NOTE: every output gets a default value first. Without it, a path
      // that skips an assignment would infer a latch.
      dec_acc  = '0;
      dec_cnt  = '0;
      dec_left = 1'b0;
      if (exp_f != 5'd31 && exp_f >= 5'd14) begin
         dec_acc = {6'd0, mant};
         if (exp_f < 5'd24) begin
            dec_cnt = 5'd24 - exp_f;
         end else begin
            dec_cnt  = exp_f - 5'd24;
            dec_left = 1'b1;
         end
      end
   end

   // Round: adding the guard bit to the integer part gives
   // floor(|v| + 0.5), which is round-to-nearest with ties away from zero.
   // A carry cannot overflow: the guard bit can only be set when the
   // magnitude is at most 1024.
   logic [15:0] mag;
   logic [15:0] neg_mag;
   logic [15:0] rnd_res;

   assign mag     = acc_q[16:1] + {15'd0, acc_q[0]};
   assign neg_mag = ~mag + 16'd1;

   always_comb begin
      rnd_res = sign ? neg_mag : mag;
`ifdef FLT2INT_SAT_EN
      if (exp_f == 5'd31) begin
         rnd_res = sign ? 16'h8000 : 16'h7FFF;
      end else if (!sign && mag > 16'h7FFF) begin
         rnd_res = 16'h7FFF;
      end else if (sign && mag > 16'h8000) begin
         rnd_res = 16'h8000;
      end
`else
      if (exp_f == 5'd31) rnd_res = 16'h8000;
`endif
   end

   // Memory port usage. The write is gated by reset, so an aborted
   // conversion cannot commit a half-written result on the reset edge.
   assign mem_we    = (state_q == S_STORE_HI || state_q == S_STORE_LO) && !reset;
   assign mem_waddr = (state_q == S_STORE_HI) ? AW'(ADDR_OUT) : AW'(ADDR_OUT + 1);
   assign mem_wdata = (state_q == S_STORE_HI) ? res_q[15:8] : res_q[7:0];

   fp16_to_int16_dm #(.DEPTH(DM_DEPTH)) dm1 (
      .clk       (clk),
      .we_i      (mem_we),
      .waddr_i   (mem_waddr),
      .wdata_i   (mem_wdata),
      .raddr_a_i (AW'(ADDR_IN)),
      .raddr_b_i (AW'(ADDR_IN + 1)),
      .rdata_a_o (rd_hi),
      .rdata_b_o (rd_lo)
   );

   // NOTE: sequential state uses non-blocking assignments only. All
   // registers then update together at the clock edge, independent of
   // statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         res_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  state_q <= S_LOAD;
                  ack_q   <= 1'b0;
               end
            end
            S_LOAD: begin
               op_q    <= {rd_hi, rd_lo};
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               acc_q   <= dec_acc;
               cnt_q   <= dec_cnt;
               left_q  <= dec_left;
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               if (cnt_q == 5'd0) begin
                  state_q <= S_ROUND;
               end else begin
                  acc_q <= left_q ? (acc_q << 1) : (acc_q >> 1);
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            S_ROUND: begin
               res_q   <= rnd_res;
               state_q <= S_STORE_HI;
            end
            S_STORE_HI: begin
               state_q <= S_STORE_LO;
            end
            S_STORE_LO: begin
               // The low byte commits on this edge, so memory is
               // complete by the time ack is seen high.
               ack_q   <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               if (req) begin
                  state_q <= S_LOAD;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ack = ack_q;

endmodule

// File: tb/tb_fp16_to_int16.sv
// -----------------------------------------------------------------------------
// tb_fp16_to_int16
//   Self-checking bench for fp16_to_int16. Operands are written into the
//   data memory by backdoor and req is pulsed. The bench then waits, with a
//   bound, for ack and reads the result bytes back from memory.
//   Expected values come either from a directed table or from a reference
//   model that evaluates the real-valued float and rounds it arithmetically.
// -----------------------------------------------------------------------------
module tb_fp16_to_int16;

   localparam int MAX_LAT = 48;

   logic clk;
   logic reset;
   logic req;
   logic ack;

   int n_asserts = 0;
   int n_fail    = 0;

   fp16_to_int16 dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .ack   (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: value = (-1)^s * m * 2^(e-25), rounded by
   // floor(|v| + 0.5), then sign-applied and truncated to 16 bits.
   function automatic logic [15:0] ref_conv(input logic [15:0] op);
      int  e;
      int  m;
      int  mag;
      real av;
      e  = int'(op[14:10]);
      m  = ((e != 0) ? 1024 : 0) + int'(op[9:0]);
`ifdef FLT2INT_SAT_EN
      if (e == 31) return op[15] ? 16'h8000 : 16'h7FFF;
`else
      if (e == 31) return 16'h8000;
`endif
      av = real'(m);
      if (e >= 25) begin
         for (int k = 0; k < e - 25; k++) av = av * 2.0;
      end else begin
         for (int k = 0; k < 25 - e; k++) av = av / 2.0;
      end
      mag = $rtoi(av + 0.5);
`ifdef FLT2INT_SAT_EN
      if (!op[15] && mag > 32767) return 16'h7FFF;
      if (op[15] && mag > 32768) return 16'h8000;
`endif
      return op[15] ? 16'(-mag) : 16'(mag);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   task automatic run_conv(input logic [15:0] op, input logic [15:0] exp, input string tag);
      bit seen;
      dut.dm1.mem_core[4] = op[15:8];
      dut.dm1.mem_core[5] = op[7:0];
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check({tag, "/ack_drop"}, {15'd0, ack}, 16'd0);
      seen = 1'b0;
      for (int c = 0; c < MAX_LAT && !seen; c++) begin
         @(negedge clk);
         if (ack === 1'b1) seen = 1'b1;
      end
      check({tag, "/ack_in_time"}, {15'd0, seen}, 16'd1);
      check({tag, "/result"}, {dut.dm1.mem_core[6], dut.dm1.mem_core[7]}, exp);
   endtask

   // Directed operands and their expected results in the default build
   localparam int N_DIR = 26;
   logic [15:0] dir_op  [N_DIR] = '{
      16'h0000, 16'h3C00, 16'h3E00, 16'h3D00, 16'h4200, 16'h4380, 16'h4040,
      16'h4140, 16'h4B00, 16'h6300, 16'h6700, 16'h7780, 16'h7B80, 16'hBE00,
      16'h7C00, 16'h3800, 16'h3400, 16'h3BFF, 16'h0001, 16'hFC00, 16'h7BFF,
      16'hFBFF, 16'hB800, 16'h7E00, 16'h4100, 16'hC500};
   logic [15:0] dir_exp [N_DIR] = '{
      16'h0000, 16'h0001, 16'h0002, 16'h0001, 16'h0003, 16'h0004, 16'h0002,
      16'h0003, 16'h000E, 16'h0380, 16'h0700, 16'h7800, 16'hF000, 16'hFFFE,
      16'h8000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'hFFE0,
      16'h0020, 16'hFFFF, 16'h8000, 16'h0003, 16'hFFFB};

   initial begin
      logic [15:0] exp_v;
      logic [31:0] rnd;
      logic [15:0] op;
      bit          seen;

      reset = 1'b1;
      req   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset/ack", {15'd0, ack}, 16'd0);

      // Directed values. Each request is issued while ack=1 from the
      // previous one, so this doubles as the back-to-back test.
      for (int i = 0; i < N_DIR; i++) begin
`ifdef FLT2INT_SAT_EN
         exp_v = ref_conv(dir_op[i]);
`else
         exp_v = dir_exp[i];
`endif
         run_conv(dir_op[i], exp_v, $sformatf("dir_%04h", dir_op[i]));
      end

      // ack must hold while DONE with no request
      repeat (3) @(negedge clk);
      check("done/ack_hold", {15'd0, ack}, 16'd1);

      // Reset while DONE clears ack
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_in_done/ack", {15'd0, ack}, 16'd0);

      // Reset in the middle of a conversion aborts it
      dut.dm1.mem_core[4] = 8'h4B;
      dut.dm1.mem_core[5] = 8'h00;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("reset_mid/ack", {15'd0, ack}, 16'd0);
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (ack !== 1'b0) seen = 1'b1;
      end
      check("reset_mid/stays_idle", {15'd0, seen}, 16'd0);
      run_conv(16'h4380, ref_conv(16'h4380), "after_reset");

      // Random operands checked against the reference model
      for (int i = 0; i < 60; i++) begin
         rnd = $urandom();
         op  = rnd[15:0];
         run_conv(op, ref_conv(op), $sformatf("rnd%0d_%04h", i, op));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
